uart_rx_fsm: RTL and testbench
==============================

UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 Parameter PRESCALE_W, default 6: width of the prescale and edge counter.
REQ-003 clk  input  1: single receive clock, oversampled relative to the baud rate.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 RX_IN  input  1: serial line, idle high.
REQ-006 PAR_EN  input  1: 1 means the frame carries a parity bit.
REQ-007 Prescale  input  PRESCALE_W: oversampling ratio per bit; legal values are 8, 16 and 32.
REQ-008 strt_glitch, par_err, stp_err  input  1 each: registered checker results, valid the cycle after their enable pulse.
REQ-009 edge_cnt  output  PRESCALE_W: position of the current oversample within the bit.
REQ-010 bit_cnt  output  4: index of the current frame bit (0 = start bit).
REQ-011 dat_samp_en  output  1: sampler enable.
REQ-012 deser_en, strt_chk_en, par_chk_en, stp_chk_en  output  1 each: single-cycle enable pulses.
REQ-013 data_valid  output  1: one-cycle pulse marking a good frame.

Function
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 Sampling point SMP SHALL be Prescale/2+2; end-of-bit point EOB SHALL be Prescale-1.
REQ-016 In IDLE, RX_IN==0 SHALL move the FSM to START on the next edge with edge_cnt=0 and bit_cnt=0.
REQ-017 Outside IDLE, edge_cnt SHALL increment every cycle and wrap EOB->0; bit_cnt SHALL increment on each wrap.
REQ-018 dat_samp_en SHALL be 1 in every state except IDLE.
REQ-019 At edge_cnt==SMP: strt_chk_en pulses in START, deser_en in DATA, par_chk_en in PARITY, stp_chk_en in STOP.
REQ-020 START at EOB: if strt_glitch==1, go to IDLE and clear both counters; otherwise go to DATA.
REQ-021 DATA at EOB of bit_cnt==DATA_WIDTH: go to PARITY if PAR_EN==1, else go to STOP.
REQ-022 PARITY at EOB: always go to STOP; par_err is latched for the final decision.
REQ-023 STOP at EOB: data_valid SHALL pulse for one cycle iff stp_err==0 and (PAR_EN==0 or par_err==0).
REQ-024 STOP at EOB, next state: go to START (counters 0) if RX_IN==0 (back-to-back frame), else go to IDLE.
REQ-025 PAR_EN and Prescale SHALL be sampled on the IDLE->START transition and held for the whole frame.
REQ-026 Every output except the counters SHALL be 0 in IDLE.

Reset
REQ-027 While reset==0: state=IDLE, edge_cnt=0, bit_cnt=0, all enables=0, data_valid=0, asynchronously, including mid-frame.
REQ-028 After reset deasserts, the first reception SHALL begin only on a fresh RX_IN low sampled in IDLE.

Configuration
REQ-029 Macro UART_RX_ERR_CNT_EN SHALL control an added output frm_err_cnt (8 bits).
REQ-030 With UART_RX_ERR_CNT_EN defined: frm_err_cnt increments, saturating at 255, on each STOP EOB where data_valid is not asserted; it resets to 0.
REQ-031 Without UART_RX_ERR_CNT_EN: port frm_err_cnt and its logic SHALL be absent.

Structure
REQ-032 A shared package SHALL hold the state enum, the SMP offset constant (2) and the legal Prescale constants.
REQ-033 Sub-module edge_bit_counter SHALL hold edge_cnt and bit_cnt; its enable and clear inputs SHALL be driven by the FSM.

Verification
REQ-034 Prescale=8, PAR_EN=1, even parity, frame 0xA5 with parity 0 and stop 1 -> one data_valid pulse exactly 88 cycles after the start edge; deser_en pulses 8 times.
REQ-035 RX_IN low for 3 cycles then high (strt_glitch=1) -> return to IDLE at edge_cnt==7 of bit 0; no deser_en pulse.
REQ-036 PAR_EN=1, par_err=1 -> no data_valid pulse; frm_err_cnt increments by 1 (macro on).
REQ-037 stp_err=1 with PAR_EN=0 -> no data_valid pulse, return to IDLE.
REQ-038 Two back-to-back frames (0x3C, 0xC3) at Prescale=16 -> two data_valid pulses 160 cycles apart, with no IDLE cycle between frames.
REQ-039 reset asserted during DATA bit 4 -> all outputs 0 immediately; the next frame is received cleanly; frm_err_cnt saturates at 255 after 300 bad frames.

Source files
------------

// File: rtl/uart_rx_fsm_pkg.sv
// uart_rx_fsm_pkg: state encoding, sampling offset and legal oversampling ratios for the UART receiver
package uart_rx_fsm_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam int SMP_OFS  = 2;
  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;
  function automatic logic presc_legal(input int p);
    return p == PRESC_8 || p == PRESC_16 || p == PRESC_32;
  endfunction
endpackage

// File: rtl/edge_bit_counter.sv
// edge_bit_counter: oversample position within a bit and frame bit index, sequenced by the receive FSM
module edge_bit_counter #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [PRESCALE_W-1:0] eob_i,
  output logic [PRESCALE_W-1:0] edge_cnt_o,
  output logic [3:0]            bit_cnt_o
);
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic wrap;
  always_comb begin
    wrap       = edge_cnt_q == eob_i;
    edge_cnt_d = clr_i ? '0 : en_i ? (wrap ? '0 : edge_cnt_q + 1'b1) : edge_cnt_q;
    bit_cnt_d  = clr_i ? '0 : (en_i && wrap) ? bit_cnt_q + 1'b1 : bit_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end
  assign edge_cnt_o = edge_cnt_q;
  assign bit_cnt_o  = bit_cnt_q;
endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive control FSM driving the sampler, deserializer and start/parity/stop checkers.
// Define UART_RX_ERR_CNT_EN to add frm_err_cnt, an 8-bit saturating count of rejected frames.
module uart_rx_fsm
  import uart_rx_fsm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]            frm_err_cnt
`endif
);
  state_e state_q, state_d;
  logic par_en_q, par_err_q;
  logic [PRESCALE_W-1:0] prescale_q, eob, smp_pre;
  logic eob_hit, frame_start, frame_ok, cnt_en, cnt_clr, stop_eob;
  always_comb begin
    eob     = prescale_q - 1'b1;
    smp_pre = (prescale_q >> 1) + PRESCALE_W'(SMP_OFS - 1);
    eob_hit = edge_cnt == eob;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RX_IN ? IDLE : START;
      START:   state_d = !eob_hit ? START : strt_glitch ? IDLE : DATA;
      DATA:    state_d = (eob_hit && bit_cnt == 4'(DATA_WIDTH)) ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY:  state_d = eob_hit ? STOP : PARITY;
      STOP:    state_d = !eob_hit ? STOP : RX_IN ? IDLE : START;
      default: state_d = IDLE;
    endcase
    frame_start = state_d == START && state_q != START;
    frame_ok    = !stp_err && (!par_en_q || !par_err_q);
    stop_eob    = state_q == STOP && eob_hit;
    cnt_en      = state_q != IDLE;
    cnt_clr     = !cnt_en || (eob_hit && (state_d == IDLE || state_d == START));
  end
  edge_bit_counter #(.PRESCALE_W(PRESCALE_W)) u_edge_bit_counter (
    .clk        (clk),
    .rst_ni     (reset),
    .en_i       (cnt_en),
    .clr_i      (cnt_clr),
    .eob_i      (eob),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt)
  );
  // checker strobes are registered one count early so they line up with edge_cnt == SMP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      par_en_q    <= 1'b0;
      par_err_q   <= 1'b0;
      prescale_q  <= PRESCALE_W'(PRESC_8);
      dat_samp_en <= 1'b0;
      deser_en    <= 1'b0;
      strt_chk_en <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
`ifdef UART_RX_ERR_CNT_EN
      frm_err_cnt <= '0;
`endif
    end else begin
      state_q     <= state_d;
      par_en_q    <= frame_start ? PAR_EN : par_en_q;
      prescale_q  <= !frame_start ? prescale_q : presc_legal(int'(Prescale)) ? Prescale : PRESCALE_W'(PRESC_8);
      par_err_q   <= frame_start ? 1'b0 : (state_q == PARITY && eob_hit) ? par_err : par_err_q;
      dat_samp_en <= state_d != IDLE;
      strt_chk_en <= state_q == START && edge_cnt == smp_pre;
      deser_en    <= state_q == DATA && edge_cnt == smp_pre;
      par_chk_en  <= state_q == PARITY && edge_cnt == smp_pre;
      stp_chk_en  <= state_q == STOP && edge_cnt == smp_pre;
      data_valid  <= stop_eob && frame_ok;
`ifdef UART_RX_ERR_CNT_EN
      frm_err_cnt <= (stop_eob && !frame_ok && frm_err_cnt != 8'hFF) ? frm_err_cnt + 1'b1 : frm_err_cnt;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed frames with hand-computed pulse counts, latencies and counter positions
module tb_uart_rx_fsm;
  logic clk = 1'b0, reset = 1'b0, RX_IN = 1'b1, PAR_EN = 1'b0;
  logic strt_glitch = 1'b0, par_err = 1'b0, stp_err = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;
  logic [5:0] outs;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] frm_err_cnt;
`endif
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int n_des = 0, n_sc = 0, n_pc = 0, n_stc = 0, n_idle = 0, des_edge = 0;
  int dv0, des0, sc0, pc0, st0, id0;
  int dv_q[$];
  uart_rx_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .Prescale    (Prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid)
`ifdef UART_RX_ERR_CNT_EN
    ,
    .frm_err_cnt (frm_err_cnt)
`endif
  );
  assign outs = {dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (data_valid) dv_q.push_back(cyc);
    if (deser_en) begin
      n_des++;
      des_edge = int'(edge_cnt);
    end
    if (strt_chk_en) n_sc++;
    if (par_chk_en) n_pc++;
    if (stp_chk_en) n_stc++;
    if (!dat_samp_en) n_idle++;
  end
  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic snap();
    dv0 = dv_q.size(); des0 = n_des; sc0 = n_sc; pc0 = n_pc; st0 = n_stc; id0 = n_idle;
  endtask
  function automatic int lat(input int i, input int t);
    return dv_q.size() > i ? dv_q[i] - t : -1;
  endfunction
  task automatic send(input int p, input bit pe, input logic [7:0] d, input bit pb, input bit b2b, output int t0);
    logic [10:0] f;
    int n;
    n = pe ? 11 : 10;
    f = {1'b1, pe ? pb : 1'b1, d, 1'b0};
    Prescale = 6'(p); PAR_EN = pe; RX_IN = 1'b0;
    t0 = 0;
    for (int c = 0; c < n * p; c++) begin
      step();
      if (c == 0) begin
        t0 = cyc;
        PAR_EN = !pe;
        Prescale = (p == 16) ? 6'd8 : 6'd16;
      end
      RX_IN = (b2b && c == n * p - 1) ? 1'b0 : f[c / p];
    end
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t0, t1, e0;
    e0 = 0;
    step(2);
    check("rst_outs", int'(outs), 0);
    check("rst_edge", int'(edge_cnt), 0);
    check("rst_bit", int'(bit_cnt), 0);
`ifdef UART_RX_ERR_CNT_EN
    check("rst_errcnt", int'(frm_err_cnt), 0);
`endif
    reset = 1'b1;
    step(4);
    check("idle_outs", int'(outs), 0);
    snap();
    send(8, 1'b1, 8'hA5, 1'b0, 1'b0, t0);
    check("t1_edge_eob", int'(edge_cnt), 7);
    check("t1_bit_stop", int'(bit_cnt), 10);
    check("t1_samp_stop", int'(dat_samp_en), 1);
    step();
    check("t1_dv_pulse", int'(data_valid), 1);
    check("t1_samp_idle", int'(dat_samp_en), 0);
    check("t1_bit_clr", int'(bit_cnt), 0);
    step();
    check("t1_dv_single", int'(data_valid), 0);
    check("t1_dv_count", dv_q.size() - dv0, 1);
    check("t1_dv_latency", lat(dv0, t0), 88);
    check("t1_deser", n_des - des0, 8);
    check("t1_smp8", des_edge, 6);
    check("t1_strt_chk", n_sc - sc0, 1);
    check("t1_par_chk", n_pc - pc0, 1);
    check("t1_stp_chk", n_stc - st0, 1);
    Prescale = 6'd8; PAR_EN = 1'b0; strt_glitch = 1'b1;
    snap();
    RX_IN = 1'b0;
    step(2);
    RX_IN = 1'b1;
    step(6);
    check("t2_edge7", int'(edge_cnt), 7);
    check("t2_bit0", int'(bit_cnt), 0);
    check("t2_samp_start", int'(dat_samp_en), 1);
    step();
    check("t2_back_idle", int'(dat_samp_en), 0);
    check("t2_edge_clr", int'(edge_cnt), 0);
    step(10);
    check("t2_stay_idle", int'(outs), 0);
    check("t2_deser", n_des - des0, 0);
    check("t2_strt_chk", n_sc - sc0, 1);
    strt_glitch = 1'b0;
    par_err = 1'b1;
`ifdef UART_RX_ERR_CNT_EN
    e0 = int'(frm_err_cnt);
`endif
    snap();
    send(8, 1'b1, 8'h0F, 1'b0, 1'b0, t0);
    step(3);
    check("t3_dv_count", dv_q.size() - dv0, 0);
    check("t3_par_chk", n_pc - pc0, 1);
`ifdef UART_RX_ERR_CNT_EN
    check("t3_errcnt", int'(frm_err_cnt), e0 + 1);
`endif
    par_err = 1'b0; stp_err = 1'b1;
    snap();
    send(8, 1'b0, 8'h33, 1'b0, 1'b0, t0);
    step();
    check("t4_idle", int'(dat_samp_en), 0);
    step(2);
    check("t4_dv_count", dv_q.size() - dv0, 0);
    check("t4_stp_chk", n_stc - st0, 1);
`ifdef UART_RX_ERR_CNT_EN
    check("t4_errcnt", int'(frm_err_cnt), e0 + 2);
`endif
    stp_err = 1'b0; par_err = 1'b1;
    snap();
    send(8, 1'b0, 8'h96, 1'b0, 1'b0, t0);
    step(3);
    check("t4b_dv_count", dv_q.size() - dv0, 1);
    check("t4b_dv_latency", lat(dv0, t0), 80);
    check("t4b_par_chk", n_pc - pc0, 0);
    par_err = 1'b0;
    snap();
    send(16, 1'b0, 8'h3C, 1'b0, 1'b1, t0);
    id0 = n_idle;
    send(16, 1'b0, 8'hC3, 1'b0, 1'b0, t1);
    check("t5_no_idle", n_idle - id0, 0);
    check("t5_start_gap", t1 - t0, 160);
    step(3);
    check("t5_dv_count", dv_q.size() - dv0, 2);
    check("t5_dv_latency", lat(dv0, t0), 160);
    check("t5_dv_spacing", lat(dv0 + 1, t0) - lat(dv0, t0), 160);
    check("t5_deser", n_des - des0, 16);
    check("t5_smp16", des_edge, 10);
    Prescale = 6'd8; PAR_EN = 1'b0;
    snap();
    RX_IN = 1'b0;
    step();
    RX_IN = 1'b1;
    step(35);
    check("t6_bit4", int'(bit_cnt), 4);
    check("t6_samp_data", int'(dat_samp_en), 1);
    reset = 1'b0;
    #1;
    check("t6_async_outs", int'(outs), 0);
    check("t6_async_edge", int'(edge_cnt), 0);
    check("t6_async_bit", int'(bit_cnt), 0);
    step();
    reset = 1'b1;
    step(5);
    check("t6_no_restart", int'(outs), 0);
`ifdef UART_RX_ERR_CNT_EN
    check("t6_errcnt_rst", int'(frm_err_cnt), 0);
`endif
    snap();
    send(8, 1'b0, 8'h5A, 1'b0, 1'b0, t0);
    step(3);
    check("t6_dv_count", dv_q.size() - dv0, 1);
    check("t6_dv_latency", lat(dv0, t0), 80);
    check("t6_deser", n_des - des0, 8);
    snap();
    send(32, 1'b1, 8'h81, 1'b0, 1'b0, t0);
    step(3);
    check("t7_dv_latency", lat(dv0, t0), 352);
    check("t7_smp32", des_edge, 18);
    check("t7_deser", n_des - des0, 8);
`ifdef UART_RX_ERR_CNT_EN
    stp_err = 1'b1;
    snap();
    for (int i = 0; i < 300; i++) send(8, 1'b0, 8'hFF, 1'b0, i < 299, t0);
    step(3);
    check("t8_errcnt_sat", int'(frm_err_cnt), 255);
    check("t8_dv_count", dv_q.size() - dv0, 0);
    stp_err = 1'b0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
